// File: rtl/axi_mem_responder.sv
// AXI4 responder memory model: one burst at a time, word-addressed 64-bit backing array,
// programmable read latency, byte-strobed writes, SLVERR for beats outside the array.
module axi_mem_responder #(
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [63:0] BASE_ADDR    = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [63:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic        s_axi_rlast,
  output logic [1:0]  s_axi_rresp,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t      state;
  logic        pref_read;
  logic [60:0] idx;
  logic [7:0]  len;
  logic [7:0]  beat;
  logic [1:0]  burst;
  logic        below;
  logic [31:0] lat_cnt;
  logic        wr_err;

  logic [63:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [60:0] i, input logic b);
    return !b && (i < 61'(MEM_WORDS));
  endfunction

  // FIXED bursts revisit the same word; INCR, WRAP and reserved all advance.
  function automatic logic [60:0] step_idx(input logic [60:0] i, input logic [1:0] bt);
    return (bt == 2'b00) ? i : i + 61'd1;
  endfunction

  logic [63:0] ar_off, aw_off;
  logic        ar_below, aw_below;
  logic        ar_go, aw_go, w_go;

  assign ar_off   = s_axi_araddr - BASE_ADDR;
  assign aw_off   = s_axi_awaddr - BASE_ADDR;
  assign ar_below = s_axi_araddr < BASE_ADDR;
  assign aw_below = s_axi_awaddr < BASE_ADDR;

  logic unused_ok;
  assign unused_ok = ^{s_axi_arsize, s_axi_awsize, ar_off[2:0], aw_off[2:0]};

  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_awready = 1'b0;
    if (!reset && state == IDLE) begin
      s_axi_arready = s_axi_arvalid && (pref_read || !s_axi_awvalid);
      s_axi_awready = s_axi_awvalid && !(s_axi_arvalid && (pref_read || !s_axi_awvalid));
    end
  end

  assign ar_go = s_axi_arvalid && s_axi_arready;
  assign aw_go = s_axi_awvalid && s_axi_awready;
  assign w_go  = !reset && state == WR_DATA && s_axi_wready && s_axi_wvalid;

  // Source of the next R beat: the AR channel itself when latency is zero,
  // the latched index for the first beat, the stepped index thereafter.
  logic [60:0] ld_idx;
  logic        ld_below;
  logic        ld_last;
  logic        ld_ok;
  logic [63:0] ld_data;

  always_comb begin
    ld_idx   = idx;
    ld_below = below;
    ld_last  = (len == 8'd0);
    if (state == IDLE) begin
      ld_idx   = ar_off[63:3];
      ld_below = ar_below;
      ld_last  = (s_axi_arlen == 8'd0);
    end else if (state == RD_DATA) begin
      ld_idx  = step_idx(idx, burst);
      ld_last = (beat + 8'd1 == len);
    end
  end

  assign ld_ok   = in_range(ld_idx, ld_below);
  assign ld_data = ld_ok ? mem[ld_idx[IDX_W-1:0]] : 64'h0;

  logic wr_beat_ok;
  assign wr_beat_ok = in_range(idx, below);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pref_read    <= 1'b1;
      s_axi_rvalid <= 1'b0;
      s_axi_rlast  <= 1'b0;
      s_axi_rdata  <= 64'h0;
      s_axi_rresp  <= 2'b00;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (ar_go || aw_go) begin
            if (s_axi_arvalid && s_axi_awvalid) pref_read <= ~pref_read;
            beat <= 8'd0;
          end
          if (ar_go) begin
            idx   <= ar_off[63:3];
            len   <= s_axi_arlen;
            burst <= s_axi_arburst;
            below <= ar_below;
            if (READ_LATENCY == 0) begin
              s_axi_rvalid <= 1'b1;
              s_axi_rdata  <= ld_data;
              s_axi_rresp  <= ld_ok ? 2'b00 : 2'b10;
              s_axi_rlast  <= ld_last;
              state        <= RD_DATA;
            end else begin
              lat_cnt <= 32'(READ_LATENCY);
              state   <= RD_WAIT;
            end
          end else if (aw_go) begin
            idx          <= aw_off[63:3];
            len          <= s_axi_awlen;
            burst        <= s_axi_awburst;
            below        <= aw_below;
            wr_err       <= 1'b0;
            s_axi_wready <= 1'b1;
            state        <= WR_DATA;
          end
        end
        RD_WAIT: begin
          if (lat_cnt <= 32'd1) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= ld_data;
            s_axi_rresp  <= ld_ok ? 2'b00 : 2'b10;
            s_axi_rlast  <= ld_last;
            state        <= RD_DATA;
          end else begin
            lat_cnt <= lat_cnt - 32'd1;
          end
        end
        RD_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid <= 1'b0;
              s_axi_rlast  <= 1'b0;
              state        <= IDLE;
            end else begin
              idx         <= ld_idx;
              beat        <= beat + 8'd1;
              s_axi_rdata <= ld_data;
              s_axi_rresp <= ld_ok ? 2'b00 : 2'b10;
              s_axi_rlast <= ld_last;
            end
          end
        end
        WR_DATA: begin
          if (w_go) begin
            if (!wr_beat_ok) wr_err <= 1'b1;
            idx  <= step_idx(idx, burst);
            beat <= beat + 8'd1;
            if (s_axi_wlast) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (wr_err || !wr_beat_ok || beat != len) ? 2'b10 : 2'b00;
              state        <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backing store is never reset; writes land on their W handshake edge.
  always_ff @(posedge clk) begin
    if (w_go && wr_beat_ok) begin
      for (int i = 0; i < 8; i++) begin
        if (s_axi_wstrb[i]) mem[idx[IDX_W-1:0]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: directed bursts push expected R/B responses,
// a negedge monitor pops and compares every handshake and watches stall stability.
module tb_axi_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [63:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'd3;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic        s_axi_rvalid, s_axi_rready = 1'b0;
  logic [63:0] s_axi_rdata;
  logic        s_axi_rlast;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [63:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'd3;
  logic [1:0]  s_axi_awburst = 2'b01;
  logic        s_axi_wvalid = 1'b0, s_axi_wready;
  logic [63:0] s_axi_wdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_bvalid, s_axi_bready = 1'b0;
  logic [1:0]  s_axi_bresp;

  axi_mem_responder dut (
    .clk(clk), .reset(reset),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rlast(s_axi_rlast), .s_axi_rresp(s_axi_rresp),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  r;
    logic        l;
  } rexp_t;

  rexp_t      rq[$];
  logic [1:0] bq[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_r(input logic [63:0] d, input logic [1:0] r, input logic l);
    rexp_t e;
    e.d = d; e.r = r; e.l = l;
    rq.push_back(e);
  endtask

  bit    stall_p = 1'b0;
  rexp_t stall_v;

  always @(negedge clk) begin
    rexp_t e;
    if (stall_p)
      chk({s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast} === {1'b1, stall_v}, "r_stable",
          {s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, {1'b1, stall_v});
    if (s_axi_rvalid && s_axi_rready) begin
      if (rq.size() == 0) chk(1'b0, "r_unexpected", s_axi_rdata, 0);
      else begin
        e = rq.pop_front();
        chk({s_axi_rdata, s_axi_rresp, s_axi_rlast} === e, "r_beat",
            {s_axi_rdata, s_axi_rresp, s_axi_rlast}, e);
      end
    end
    if (s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) chk(1'b0, "b_unexpected", s_axi_bresp, 0);
      else chk(s_axi_bresp === bq.pop_front(), "bresp", s_axi_bresp, 0);
    end
    stall_p = s_axi_rvalid && !s_axi_rready;
    stall_v = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
  end

  task automatic read_burst(input logic [63:0] a, input logic [7:0] len, input logic [1:0] bt,
                            input bit tog, output int t_hs, output int t_first);
    int n;
    bit done;
    t_hs = -1;
    t_first = -1;
    @(posedge clk); #1;
    s_axi_araddr = a; s_axi_arlen = len; s_axi_arburst = bt;
    s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (s_axi_arready) break;
      n++;
      if (n > 300) begin
        chk(1'b0, "ar_timeout", 0, 1);
        s_axi_arvalid = 1'b0;
        return;
      end
    end
    t_hs = cyc;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (s_axi_rvalid && t_first < 0) t_first = cyc;
      if (s_axi_rvalid && s_axi_rready && s_axi_rlast) done = 1'b1;
      else begin
        n++;
        if (n > 300) begin
          chk(1'b0, "r_timeout", 0, 1);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (tog && !done) s_axi_rready = ~s_axi_rready;
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic write_burst(input logic [63:0] a, input logic [7:0] len, input int nb,
                             input logic [63:0] d0, input logic [7:0] strb, input logic [1:0] exp,
                             output int t_hs);
    int n;
    t_hs = -1;
    bq.push_back(exp);
    @(posedge clk); #1;
    s_axi_awaddr = a; s_axi_awlen = len; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (s_axi_awready) break;
      n++;
      if (n > 300) begin
        chk(1'b0, "aw_timeout", 0, 1);
        s_axi_awvalid = 1'b0;
        return;
      end
    end
    t_hs = cyc;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int k = 0; k < nb; k++) begin
      s_axi_wdata = d0 + 64'(k); s_axi_wstrb = strb; s_axi_wlast = (k == nb - 1); s_axi_wvalid = 1'b1;
      n = 0;
      while (1) begin
        @(negedge clk);
        if (s_axi_wready) break;
        n++;
        if (n > 300) begin
          chk(1'b0, "w_timeout", 0, 1);
          s_axi_wvalid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (s_axi_bvalid) break;
      n++;
      if (n > 300) begin
        chk(1'b0, "b_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tf, tw, n, hs;

    repeat (2) @(negedge clk);
    chk({s_axi_arready, s_axi_awready, s_axi_rvalid, s_axi_rlast, s_axi_wready, s_axi_bvalid} === 6'b0,
        "reset_ctrl", {s_axi_arready, s_axi_awready, s_axi_rvalid, s_axi_rlast, s_axi_wready, s_axi_bvalid}, 0);
    chk({s_axi_rdata, s_axi_rresp, s_axi_bresp} === 68'h0, "reset_data",
        {s_axi_rdata, s_axi_rresp, s_axi_bresp}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single word write then read with latency measurement.
    write_burst(64'h40, 8'd0, 1, 64'h1122334455667788, 8'hFF, 2'b00, tw);
    push_r(64'h1122334455667788, 2'b00, 1'b1);
    read_burst(64'h40, 8'd0, 2'b01, 1'b0, ta, tf);
    chk(tf - ta == 3, "rd_latency", tf - ta, 3);

    // 8-beat INCR write of k, read back with rready toggling.
    write_burst(64'h100, 8'd7, 8, 64'h0, 8'hFF, 2'b00, tw);
    for (int k = 0; k < 8; k++) push_r(64'(k), 2'b00, k == 7);
    read_burst(64'h100, 8'd7, 2'b01, 1'b1, ta, tf);

    // Partial strobe over an all-ones word.
    write_burst(64'h200, 8'd0, 1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b00, tw);
    write_burst(64'h200, 8'd0, 1, 64'h0, 8'h0F, 2'b00, tw);
    push_r(64'hFFFFFFFF00000000, 2'b00, 1'b1);
    read_burst(64'h200, 8'd0, 2'b01, 1'b0, ta, tf);

    // FIXED burst repeats one word.
    write_burst(64'h500, 8'd0, 1, 64'h77, 8'hFF, 2'b00, tw);
    for (int k = 0; k < 3; k++) push_r(64'h77, 2'b00, k == 2);
    read_burst(64'h500, 8'd2, 2'b00, 1'b0, ta, tf);

    // Two contentions: read wins first, write wins the next.
    push_r(64'h1122334455667788, 2'b00, 1'b1);
    fork
      read_burst(64'h40, 8'd0, 2'b01, 1'b0, ta, tf);
      write_burst(64'h300, 8'd0, 1, 64'hA5A5A5A55A5A5A5A, 8'hFF, 2'b00, tw);
    join
    chk(ta >= 0 && ta < tw, "grant_rd_first", ta, tw);
    push_r(64'hA5A5A5A55A5A5A5A, 2'b00, 1'b1);
    fork
      read_burst(64'h300, 8'd0, 2'b01, 1'b0, ta, tf);
      write_burst(64'h308, 8'd0, 1, 64'h0123456789ABCDEF, 8'hFF, 2'b00, tw);
    join
    chk(tw >= 0 && tw < ta, "grant_wr_first", tw, ta);

    // Out-of-range read and early-wlast write.
    push_r(64'h0, 2'b10, 1'b1);
    read_burst(64'h8000, 8'd0, 2'b01, 1'b0, ta, tf);
    write_burst(64'h400, 8'd3, 2, 64'h10, 8'hFF, 2'b10, tw);

    // Reset during beat 3 of an 8-beat read.
    for (int k = 0; k < 4; k++) push_r(64'(k), 2'b00, 1'b0);
    @(posedge clk); #1;
    s_axi_araddr = 64'h100; s_axi_arlen = 8'd7; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(s_axi_arready, "rst_ar_grant", s_axi_arready, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    hs = 0;
    while (1) begin
      @(negedge clk);
      if (s_axi_rvalid && s_axi_rready) begin
        if (hs == 3) break;
        hs++;
      end
      n++;
      if (n > 300) begin
        chk(1'b0, "rst_beat_timeout", hs, 3);
        break;
      end
    end
    reset = 1'b1;
    s_axi_araddr = 64'h40; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    @(negedge clk);
    chk({s_axi_rvalid, s_axi_rlast} === 2'b00, "rst_rvalid", {s_axi_rvalid, s_axi_rlast}, 0);
    chk(s_axi_arready === 1'b0, "rst_arready", s_axi_arready, 0);
    @(negedge clk);
    chk(s_axi_arready === 1'b0, "rst_arready2", s_axi_arready, 0);
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    push_r(64'h1122334455667788, 2'b00, 1'b1);
    read_burst(64'h40, 8'd0, 2'b01, 1'b0, ta, tf);

    repeat (3) @(negedge clk);
    chk(rq.size() == 0, "r_leftover", rq.size(), 0);
    chk(bq.size() == 0, "b_leftover", bq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
